// File: rtl/core_switch_ctrl.sv
// Dual-CPU failover controller: heartbeat watchdogs per CPU and a RUN/HOLD FSM
// that drives ctr_io, with a minimum dwell after every switch.
module core_switch_ctrl #(
    parameter int WDT_CYCLES  = 50000,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hb_a,
    input  logic       hb_b,
    input  logic       force_req,
    input  logic       force_sel,
    output logic       ctr_io,
    output logic       a_alive,
    output logic       b_alive,
    output logic       switch_pulse,
    output logic [7:0] switch_cnt
);

    localparam int WW = $clog2(WDT_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [WW-1:0] WDT_MAX   = WW'(WDT_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    // State bit 1 doubles as the CPU select (0=A, 1=B).
    localparam logic [1:0] RUN_A  = 2'd0;
    localparam logic [1:0] HOLD_A = 2'd1;
    localparam logic [1:0] RUN_B  = 2'd2;
    localparam logic [1:0] HOLD_B = 2'd3;

    logic [2:0]    sync_a_r, sync_b_r;
    logic          beat_a_s, beat_b_s;
    logic [WW-1:0] wdt_a_r, wdt_b_r, wdt_a_nxt_s, wdt_b_nxt_s;
    logic [1:0]    state_r, state_nxt_s;
    logic [HW-1:0] hold_r, hold_nxt_s;
    logic          switch_s;

    assign beat_a_s = sync_a_r[2] ^ sync_a_r[1];
    assign beat_b_s = sync_b_r[2] ^ sync_b_r[1];

    // Watchdog next values: a beat clears, otherwise count up and saturate.
    always_comb begin
        wdt_a_nxt_s = wdt_a_r;
        wdt_b_nxt_s = wdt_b_r;
        if (beat_a_s) begin
            wdt_a_nxt_s = {WW{1'b0}};
        end else if (wdt_a_r != WDT_MAX) begin
            wdt_a_nxt_s = wdt_a_r + {{(WW-1){1'b0}}, 1'b1};
        end else begin
            wdt_a_nxt_s = WDT_MAX;
        end
        if (beat_b_s) begin
            wdt_b_nxt_s = {WW{1'b0}};
        end else if (wdt_b_r != WDT_MAX) begin
            wdt_b_nxt_s = wdt_b_r + {{(WW-1){1'b0}}, 1'b1};
        end else begin
            wdt_b_nxt_s = WDT_MAX;
        end
    end

    // Heartbeat synchronisers, watchdog counters and registered alive flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a_r <= 3'b000;
            sync_b_r <= 3'b000;
            wdt_a_r  <= {WW{1'b0}};
            wdt_b_r  <= {WW{1'b0}};
            a_alive  <= 1'b1;
            b_alive  <= 1'b1;
        end else begin
            sync_a_r <= {sync_a_r[1:0], hb_a};
            sync_b_r <= {sync_b_r[1:0], hb_b};
            wdt_a_r  <= wdt_a_nxt_s;
            wdt_b_r  <= wdt_b_nxt_s;
            a_alive  <= (wdt_a_nxt_s < WDT_MAX);
            b_alive  <= (wdt_b_nxt_s < WDT_MAX);
        end
    end

    // Failover FSM: RUN states decide, HOLD states enforce the dwell and drop force_req.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        switch_s    = 1'b0;
        case (state_r)
            RUN_A: begin
                if (b_alive && (!a_alive || (force_req && force_sel))) begin
                    state_nxt_s = HOLD_B;
                    hold_nxt_s  = HOLD_LOAD;
                    switch_s    = 1'b1;
                end else begin
                    state_nxt_s = RUN_A;
                end
            end
            RUN_B: begin
                if (a_alive && (!b_alive || (force_req && !force_sel))) begin
                    state_nxt_s = HOLD_A;
                    hold_nxt_s  = HOLD_LOAD;
                    switch_s    = 1'b1;
                end else begin
                    state_nxt_s = RUN_B;
                end
            end
            HOLD_A, HOLD_B: begin
                if (hold_r == {HW{1'b0}}) begin
                    state_nxt_s = {state_r[1], 1'b0};
                end else begin
                    hold_nxt_s = hold_r - {{(HW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = RUN_A;
                hold_nxt_s  = {HW{1'b0}};
            end
        endcase
    end

    // FSM registers; ctr_io follows the next state so it changes on the switching edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= RUN_A;
            hold_r       <= {HW{1'b0}};
            ctr_io       <= 1'b0;
            switch_pulse <= 1'b0;
            switch_cnt   <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            hold_r       <= hold_nxt_s;
            ctr_io       <= state_nxt_s[1];
            switch_pulse <= switch_s;
            if (switch_s && (switch_cnt != 8'd255)) begin
                switch_cnt <= switch_cnt + 8'd1;
            end else begin
                switch_cnt <= switch_cnt;
            end
        end
    end

endmodule

// File: tb/tb_core_switch_ctrl.sv
// Scoreboard bench for core_switch_ctrl: each expected switch {ctr_io, switch_cnt}
// is queued when stimulus is driven and popped when switch_pulse appears.
module tb_core_switch_ctrl;
    localparam int WDT  = 16;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       hb_a, hb_b;
    logic       force_req, force_sel;
    logic       ctr_io, a_alive, b_alive, switch_pulse;
    logic [7:0] switch_cnt;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic       en_a, en_b;
    logic       cur_sel;
    int         exp_cnt;
    int         phase;

    core_switch_ctrl #(.WDT_CYCLES(WDT), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .hb_a(hb_a), .hb_b(hb_b),
        .force_req(force_req), .force_sel(force_sel),
        .ctr_io(ctr_io), .a_alive(a_alive), .b_alive(b_alive),
        .switch_pulse(switch_pulse), .switch_cnt(switch_cnt)
    );

    always #5 clk = ~clk;

    // Heartbeat generator: enabled CPUs toggle every 4 clk, away from the clock edge.
    initial begin
        hb_a = 1'b0; hb_b = 1'b0; phase = 0;
        forever begin
            @(posedge clk);
            #2;
            phase = phase + 1;
            if (phase == 4) begin
                phase = 0;
                if (en_a) hb_a = ~hb_a;
                if (en_b) hb_b = ~hb_b;
            end
        end
    end

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && switch_pulse === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: ctr_io=%0b cnt=%0d, no switch expected", ctr_io, switch_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                if ({ctr_io, switch_cnt} !== mon_e) begin
                    bad++;
                    $display("FAIL switch_event: got ctr_io=%0b cnt=%0d, want ctr_io=%0b cnt=%0d",
                             ctr_io, switch_cnt, mon_e[8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic expect_switch(input logic sel);
        cur_sel = sel;
        exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        exp_q.push_back({sel, 8'(exp_cnt)});
    endtask

    task automatic test_reset();
        rst = 1'b1; force_req = 1'b0; force_sel = 1'b0; en_a = 1'b0; en_b = 1'b0;
        cur_sel = 1'b0; exp_cnt = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({ctr_io, a_alive, b_alive, switch_pulse, switch_cnt} !== {4'b0110, 8'd0}) begin
            bad++;
            $display("FAIL reset_state: got io=%0b a=%0b b=%0b p=%0b cnt=%0d, want 0 1 1 0 0",
                     ctr_io, a_alive, b_alive, switch_pulse, switch_cnt);
        end
        rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
        repeat (200) @(negedge clk);
        total++;
        if ({ctr_io, a_alive, b_alive, switch_cnt} !== {3'b011, 8'd0}) begin
            bad++;
            $display("FAIL steady_run: got io=%0b a=%0b b=%0b cnt=%0d, want 0 1 1 0",
                     ctr_io, a_alive, b_alive, switch_cnt);
        end
    endtask

    task automatic test_failover();
        logic prev;
        bit   seen;
        prev = hb_a; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (hb_a !== prev) begin seen = 1'b1; en_a = 1'b0; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL hb_a_toggle: got none, want a toggle within 10 clk"); end
        expect_switch(1'b1);
        repeat (18) @(negedge clk);
        total++;
        if (a_alive !== 1'b1) begin bad++; $display("FAIL alive_before_expiry: got %0b want 1", a_alive); end
        @(negedge clk);
        total++;
        if ({a_alive, ctr_io} !== 2'b00) begin
            bad++; $display("FAIL alive_expiry: got a=%0b io=%0b want a=0 io=0", a_alive, ctr_io);
        end
        @(negedge clk);
        total++;
        if ({ctr_io, switch_pulse, switch_cnt} !== {2'b11, 8'd1}) begin
            bad++; $display("FAIL failover: got io=%0b p=%0b cnt=%0d want 1 1 1", ctr_io, switch_pulse, switch_cnt);
        end
        @(negedge clk);
        total++;
        if (switch_pulse !== 1'b0) begin bad++; $display("FAIL pulse_width: got %0b want 0", switch_pulse); end
    endtask

    task automatic test_hold_return();
        bit done;
        en_a = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
        expect_switch(1'b0);
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (b_alive === 1'b0) done = 1'b1;
            total++;
            if (ctr_io !== 1'b1) begin bad++; $display("FAIL hold_keep_b: cycle %0d got io=%0b want 1", i, ctr_io); end
        end
        total++;
        if (!done) begin bad++; $display("FAIL b_expiry_timeout: got b_alive=%0b want 0 within 60 clk", b_alive); end
        @(negedge clk);
        total++;
        if ({ctr_io, switch_cnt} !== {1'b0, 8'd2}) begin
            bad++; $display("FAIL return_to_a: got io=%0b cnt=%0d want 0 2", ctr_io, switch_cnt);
        end
        en_b = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (b_alive === 1'b1) done = 1'b1;
        end
        total++;
        if (!done) begin bad++; $display("FAIL b_revive_timeout: got b_alive=0 want 1 within 40 clk"); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_force();
        force_req = 1'b1; force_sel = 1'b1;
        expect_switch(1'b1);
        @(negedge clk);
        force_req = 1'b0;
        total++;
        if (ctr_io !== 1'b1) begin bad++; $display("FAIL force_to_b: got io=%0b want 1", ctr_io); end
        @(negedge clk);
        force_req = 1'b1; force_sel = 1'b0;
        @(negedge clk);
        force_req = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ctr_io, switch_cnt} !== {1'b1, 8'd3}) begin
            bad++; $display("FAIL force_in_hold_ignored: got io=%0b cnt=%0d want 1 3", ctr_io, switch_cnt);
        end
        repeat (10) @(negedge clk);
        force_req = 1'b1; force_sel = 1'b1;
        @(negedge clk);
        force_req = 1'b0;
        total++;
        if ({ctr_io, switch_pulse, switch_cnt} !== {2'b10, 8'd3}) begin
            bad++; $display("FAIL force_same_noop: got io=%0b p=%0b cnt=%0d want 1 0 3", ctr_io, switch_pulse, switch_cnt);
        end
        force_req = 1'b1; force_sel = 1'b0;
        expect_switch(1'b0);
        @(negedge clk);
        force_req = 1'b0;
        total++;
        if (ctr_io !== 1'b0) begin bad++; $display("FAIL force_to_a: got io=%0b want 0", ctr_io); end
        repeat (11) @(negedge clk);
    endtask

    task automatic test_both_dead();
        bit done;
        en_a = 1'b0; en_b = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (a_alive === 1'b0 && b_alive === 1'b0) done = 1'b1;
        end
        total++;
        if (!done) begin bad++; $display("FAIL both_dead_timeout: got a=%0b b=%0b want 0 0", a_alive, b_alive); end
        repeat (5) @(negedge clk);
        total++;
        if (ctr_io !== 1'b0) begin bad++; $display("FAIL both_dead_stay: got io=%0b want 0", ctr_io); end
        hb_b = ~hb_b;
        en_b = 1'b1;
        expect_switch(1'b1);
        repeat (5) @(negedge clk);
        total++;
        if ({ctr_io, switch_cnt} !== {1'b1, 8'd5}) begin
            bad++; $display("FAIL revive_b_switch: got io=%0b cnt=%0d want 1 5", ctr_io, switch_cnt);
        end
    endtask

    task automatic test_saturation();
        en_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat (HOLD + 3) @(negedge clk);
            force_req = 1'b1; force_sel = ~cur_sel;
            expect_switch(~cur_sel);
            @(negedge clk);
            force_req = 1'b0;
        end
        @(negedge clk);
        total++;
        if ({ctr_io, switch_cnt} !== {1'b1, 8'd255}) begin
            bad++; $display("FAIL saturation: got io=%0b cnt=%0d want 1 255", ctr_io, switch_cnt);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        total++;
        if ({ctr_io, a_alive, b_alive, switch_pulse, switch_cnt} !== {4'b0110, 8'd0}) begin
            bad++; $display("FAIL reset_mid_hold: got io=%0b a=%0b b=%0b p=%0b cnt=%0d want 0 1 1 0 0",
                            ctr_io, a_alive, b_alive, switch_pulse, switch_cnt);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if ({ctr_io, switch_cnt} !== {1'b0, 8'd0}) begin
            bad++; $display("FAIL after_reset_run_a: got io=%0b cnt=%0d want 0 0", ctr_io, switch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_failover();
        test_hold_return();
        test_force();
        test_both_dead();
        test_saturation();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d pending switches, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded 1 ms");
        $fatal(1, "timeout");
    end
endmodule
